// File: rtl/input_vector_loader.sv
// Ping-pong loader: groups incoming words into WEIGHT_AMOUNT-word vectors and replays each as an
// index/value/enable stream. Optional LOADER_VECTOR_COUNT_EN adds a 16-bit completed-vector counter.
module input_vector_loader #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned WEIGHT_AMOUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] output_index,
  output logic [DATA_WIDTH-1:0] output_value,
  output logic                  output_enable,
`ifdef LOADER_VECTOR_COUNT_EN
  output logic [15:0]           vector_count,
`endif
  output logic [DATA_WIDTH:0]   output_result
);

  localparam int unsigned PtrW = (WEIGHT_AMOUNT > 1) ? $clog2(WEIGHT_AMOUNT) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(WEIGHT_AMOUNT - 1);

  typedef enum logic {StIdle, StStream} state_e;

  logic [DATA_WIDTH-1:0] r_mem [2][WEIGHT_AMOUNT];
  logic [1:0]            r_full;
  logic                  r_fill_bank;
  logic                  r_drain_bank;
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  state_e                r_state;
  state_e                w_state_d;
  logic                  w_xfer;
  logic                  w_wr_last;
  logic                  w_emit;
  logic                  w_vec_end;
  logic                  w_other_full;
  logic                  w_enable_d;
  logic [DATA_WIDTH-1:0] w_index_d;
  logic [DATA_WIDTH-1:0] w_value_d;

  assign in_ready      = !rst && !r_full[r_fill_bank];
  assign w_xfer        = in_valid && in_ready;
  assign w_wr_last     = (r_wr_ptr == LastPtr);
  assign w_other_full  = r_full[~r_drain_bank];
  assign output_result = '0;

  // Bank storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_mem[r_fill_bank][r_wr_ptr] <= in_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_fill_bank <= 1'b0;
    end else if (w_xfer) begin
      if (w_wr_last) begin
        r_wr_ptr    <= '0;
        r_fill_bank <= ~r_fill_bank;
      end else begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  // Set and clear never target the same bank on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 2'b00;
    end else begin
      if (w_xfer && w_wr_last) begin
        r_full[r_fill_bank] <= 1'b1;
      end
      if (w_vec_end) begin
        r_full[r_drain_bank] <= 1'b0;
      end
    end
  end

  // Drain FSM: state register (pointers and registered outputs live here too).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_rd_ptr      <= '0;
      r_drain_bank  <= 1'b0;
      output_enable <= 1'b0;
      output_index  <= '0;
      output_value  <= '0;
    end else begin
      r_state       <= w_state_d;
      output_enable <= w_enable_d;
      output_index  <= w_index_d;
      output_value  <= w_value_d;
      if (w_vec_end) begin
        r_rd_ptr     <= '0;
        r_drain_bank <= ~r_drain_bank;
      end else if (w_emit) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Back-to-back vectors stay in StStream only when the other bank was already full.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_emit) begin
          w_state_d = (w_vec_end && !w_other_full) ? StIdle : StStream;
        end
      end
      StStream: begin
        if (w_vec_end && !w_other_full) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // rd_ptr is always zero in StIdle, so one read path serves both states.
  always_comb begin
    w_emit     = (r_state == StStream) || r_full[r_drain_bank];
    w_vec_end  = w_emit && (r_rd_ptr == LastPtr);
    w_enable_d = w_emit;
    w_index_d  = '0;
    w_value_d  = '0;
    if (w_emit) begin
      w_index_d = DATA_WIDTH'(r_rd_ptr);
      w_value_d = r_mem[r_drain_bank][r_rd_ptr];
    end
  end

`ifdef LOADER_VECTOR_COUNT_EN
  logic [15:0] r_vector_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vector_count <= '0;
    end else if (w_vec_end) begin
      r_vector_count <= r_vector_count + 16'd1;
    end
  end

  assign vector_count = r_vector_count;
`endif

endmodule

// File: tb/tb_input_vector_loader.sv
// Randomised and directed bench for input_vector_loader against a queue-based vector model.
// Define LOADER_VECTOR_COUNT_EN to also check vector_count.
module tb_input_vector_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned N  = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_value;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] output_index;
  logic [DW-1:0] output_value;
  logic          output_enable;
  logic [DW:0]   output_result;
`ifdef LOADER_VECTOR_COUNT_EN
  logic [15:0]   vector_count;
`endif

  input_vector_loader #(
    .DATA_WIDTH   (DW),
    .WEIGHT_AMOUNT(N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_value     (in_value),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .output_index (output_index),
    .output_value (output_value),
    .output_enable(output_enable),
`ifdef LOADER_VECTOR_COUNT_EN
    .vector_count (vector_count),
`endif
    .output_result(output_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: complete-but-undrained words in order, plus the vector still being collected.
  int unsigned m_done[$];
  int unsigned m_part[$];
  int unsigned m_pos = 0;
  int unsigned m_vecs = 0;
  logic          m_en = 1'b0;
  logic [DW-1:0] m_idx = '0;
  logic [DW-1:0] m_val = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned pending_vectors();
    return (m_done.size() + N - 1) / N;
  endfunction

  task automatic cycle(input logic rst_v, input logic valid_v, input logic [DW-1:0] val);
    logic ready_exp;
    @(negedge clk);
    rst      = rst_v;
    in_valid = valid_v;
    in_value = val;
    ready_exp = !rst_v && (pending_vectors() < 2);
    #1;
    check_eq("in_ready", 64'(in_ready), 64'(ready_exp));
    @(posedge clk);
    if (rst_v) begin
      m_done.delete();
      m_part.delete();
      m_pos  = 0;
      m_vecs = 0;
      m_en   = 1'b0;
      m_idx  = '0;
      m_val  = '0;
    end else begin
      if (m_done.size() > 0) begin
        m_en  = 1'b1;
        m_idx = DW'(m_pos);
        m_val = DW'(m_done.pop_front());
        m_pos = (m_pos + 1) % N;
        if (m_pos == 0) m_vecs++;
      end else begin
        m_en  = 1'b0;
        m_idx = '0;
        m_val = '0;
      end
      if (valid_v && ready_exp) begin
        m_part.push_back(int'(val));
        if (m_part.size() == N) begin
          foreach (m_part[i]) m_done.push_back(m_part[i]);
          m_part.delete();
        end
      end
    end
    #1;
    check_eq("output_enable", 64'(output_enable), 64'(m_en));
    check_eq("output_index", 64'(output_index), 64'(m_idx));
    check_eq("output_value", 64'(output_value), 64'(m_val));
    check_eq("output_result", 64'(output_result), 64'd0);
`ifdef LOADER_VECTOR_COUNT_EN
    check_eq("vector_count", 64'(vector_count), 64'(m_vecs % 65536));
`endif
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_value = '0;

    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'hdead);
    idle(2);

    // Two identical-word vectors back to back.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, (i < 4) ? 32'd1 : 32'd2);
    idle(10);

    // Three vectors, valid held high.
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, DW'(10 + i));
    idle(14);

    // One vector with single-cycle bubbles.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, DW'(40 + i));
      cycle(1'b0, 1'b0, 32'hbad);
    end
    idle(6);

    // Reset while index 1 is showing and the second bank is partly filled.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, DW'(60 + i));
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, DW'(5 + i));
    idle(6);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), DW'($urandom));
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
